// File: rtl/ram_sync_init.sv
// rtl/ram_sync_init.sv - single-port synchronous RAM with a built-in constant/address-index fill sequencer
module ram_sync_init #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  initStart,
  input  logic                  initMode,
  input  logic [DATA_WIDTH-1:0] initValue,
  output logic                  busy,
  output logic                  initDone,
  output logic                  addrError
);

  typedef enum logic {IDLE, FILL} state_t;

  // One extra counter bit so DEPTH == 2**ADDR_WIDTH reaches its last word without wrapping.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST    = DEPTH_W - 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] value_q;

  logic                  in_range;
  logic [ADDR_WIDTH+DATA_WIDTH:0] cnt_ext;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign in_range  = {1'b0, address} < DEPTH_W;
  assign cnt_ext   = {{DATA_WIDTH{1'b0}}, cnt};
  assign fill_word = mode_q ? cnt_ext[DATA_WIDTH-1:0] : value_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = dataIn;
    if (state == FILL) begin
      mem_we    = 1'b1;
      mem_waddr = cnt[ADDR_WIDTH-1:0];
      mem_wdata = fill_word;
    end else if (!initStart && we && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Storage is deliberately outside the reset domain: reset only blocks the write on its edge.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      value_q   <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      busy      <= 1'b0;
      initDone  <= 1'b0;
      addrError <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      initDone  <= 1'b0;
      addrError <= 1'b0;
      case (state)
        IDLE: begin
          if (initStart) begin
            mode_q  <= initMode;
            value_q <= initValue;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= FILL;
          end else begin
            // Read sees the pre-edge word, giving read-first behaviour against a same-edge write.
            if (re) begin
              dataValid <= 1'b1;
              dataOut   <= in_range ? mem[address] : '0;
            end
            addrError <= (we || re) && !in_range;
          end
        end
        FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy     <= 1'b0;
            initDone <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_init.sv
// tb/tb_ram_sync_init.sv - scoreboard bench for ram_sync_init at default and narrow/short geometries
module tb_ram_sync_init;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // default geometry instance: 8-bit x 32
  logic [4:0] a0 = '0;
  logic       we0 = 1'b0, re0 = 1'b0, is0 = 1'b0, im0 = 1'b0;
  logic [7:0] di0 = '0, iv0 = '0, do0;
  logic       dv0, busy0, idn0, ae0;

  // narrow instance: 4-bit x 20 with a 5-bit address
  logic [4:0] a1 = '0;
  logic       we1 = 1'b0, re1 = 1'b0, is1 = 1'b0, im1 = 1'b0;
  logic [3:0] di1 = '0, iv1 = '0, do1;
  logic       dv1, busy1, idn1, ae1;

  ram_sync_init u0 (
    .clock(clock), .reset(reset), .address(a0), .we(we0), .dataIn(di0), .re(re0),
    .dataOut(do0), .dataValid(dv0), .initStart(is0), .initMode(im0), .initValue(iv0),
    .busy(busy0), .initDone(idn0), .addrError(ae0)
  );

  ram_sync_init #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .DEPTH(20)) u1 (
    .clock(clock), .reset(reset), .address(a1), .we(we1), .dataIn(di1), .re(re1),
    .dataOut(do1), .dataValid(dv1), .initStart(is1), .initMode(im1), .initValue(iv1),
    .busy(busy1), .initDone(idn1), .addrError(ae1)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [3:0] q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: every dataValid must match the oldest expected read.
  always @(negedge clock) begin
    if (!reset && dv0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL valid0: unexpected dataValid, dataOut=%0h expected no read", do0);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        chk("read0", 32'(do0), 32'(e));
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && dv1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL valid1: unexpected dataValid, dataOut=%0h expected no read", do1);
      end else begin
        logic [3:0] e;
        e = q1.pop_front();
        chk("read1", 32'(do1), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [7:0] d);
    a0 = a; di0 = d; we0 = 1'b1;
    tick();
    we0 = 1'b0;
  endtask

  task automatic rd0(input logic [4:0] a, input logic [7:0] e);
    a0 = a; re0 = 1'b1;
    q0.push_back(e);
    tick();
    re0 = 1'b0;
  endtask

  task automatic rd1(input logic [4:0] a, input logic [3:0] e);
    a1 = a; re1 = 1'b1;
    q1.push_back(e);
    tick();
    re1 = 1'b0;
  endtask

  task automatic wait_done0(input int e_in, input int b_in, output int edges, output int busyc);
    edges = e_in;
    busyc = b_in;
    while (!idn0 && edges < 200) begin
      tick();
      edges++;
      if (busy0) busyc++;
    end
  endtask

  // Start a fill on u0; DEPTH=32 so done lands 33 edges after start with 32 busy cycles.
  task automatic fill0(input logic m, input logic [7:0] v, input logic hold);
    int e, b;
    is0 = 1'b1; im0 = m; iv0 = v;
    tick();
    if (!hold) is0 = 1'b0;
    chk("busy_start0", 32'(busy0), 32'd1);
    wait_done0(1, 1, e, b);
    chk("fill_edges0", 32'(e), 32'd33);
    chk("busy_cycles0", 32'(b), 32'd32);
    chk("initdone0", 32'(idn0), 32'd1);
    if (!hold) begin
      tick();
      chk("initdone_pulse0", 32'(idn0), 32'd0);
    end
  endtask

  initial begin
    int e, b;
    logic seen;

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_dataout", 32'(do0), 32'd0);
    chk("rst_valid", 32'(dv0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_initdone", 32'(idn0), 32'd0);
    chk("rst_addrerr", 32'(ae0), 32'd0);

    wr0(5'd3, 8'hA5);
    rd0(5'd3, 8'hA5);
    tick();
    chk("valid_one_cycle", 32'(dv0), 32'd0);

    fill0(1'b0, 8'h05, 1'b0);
    for (int i = 0; i < 20; i++) rd0(5'(i), 8'h05);

    fill0(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) rd0(5'(i), 8'(i));

    // read-first on a same-edge read+write
    wr0(5'd7, 8'h11);
    a0 = 5'd7; di0 = 8'h22; we0 = 1'b1; re0 = 1'b1;
    q0.push_back(8'h11);
    tick();
    we0 = 1'b0; re0 = 1'b0;
    chk("rw_no_addrerr", 32'(ae0), 32'd0);
    rd0(5'd7, 8'h22);
    tick();
    chk("dataout_hold", 32'(do0), 32'h22);
    chk("hold_no_valid", 32'(dv0), 32'd0);

    // we/re and mode/value changes during a fill are ignored
    is0 = 1'b1; im0 = 1'b0; iv0 = 8'h5A;
    tick();
    is0 = 1'b0;
    a0 = 5'd0; di0 = 8'hFF; we0 = 1'b1; re0 = 1'b1; im0 = 1'b1; iv0 = 8'h00;
    e = 1; b = 1; seen = 1'b0;
    repeat (20) begin
      tick();
      e++;
      if (busy0) b++;
      seen = seen | ae0;
    end
    we0 = 1'b0; re0 = 1'b0;
    wait_done0(e, b, e, b);
    chk("fill_ignore_edges", 32'(e), 32'd33);
    chk("fill_ignore_busy", 32'(b), 32'd32);
    chk("fill_ignore_addrerr", 32'(seen), 32'd0);
    tick();
    rd0(5'd0, 8'h5A);
    rd0(5'd31, 8'h5A);

    // reset after 10 fill edges: 0..9 take the fill, 10..31 keep the index pattern
    fill0(1'b1, 8'h00, 1'b0);
    is0 = 1'b1; im0 = 1'b0; iv0 = 8'h3C;
    tick();
    is0 = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_busy", 32'(busy0), 32'd0);
    chk("midreset_initdone", 32'(idn0), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | idn0 | busy0;
    end
    chk("midreset_quiet", 32'(seen), 32'd0);
    for (int i = 0; i < 10; i++) rd0(5'(i), 8'h3C);
    for (int i = 10; i < 32; i++) rd0(5'(i), 8'(i));

    // back-to-back fills with initStart held through initDone
    fill0(1'b0, 8'h77, 1'b1);
    chk("b2b_busy_gap", 32'(busy0), 32'd0);
    iv0 = 8'h66;
    tick();
    chk("b2b_restart_busy", 32'(busy0), 32'd1);
    chk("b2b_restart_done", 32'(idn0), 32'd0);
    is0 = 1'b0;
    wait_done0(1, 1, e, b);
    chk("b2b_edges", 32'(e), 32'd33);
    chk("b2b_busy", 32'(b), 32'd32);
    tick();
    rd0(5'd5, 8'h66);
    rd0(5'd31, 8'h66);

    // narrow instance: out-of-range accesses and truncated index fill
    a1 = 5'd25; di1 = 4'hF; we1 = 1'b1;
    tick();
    we1 = 1'b0;
    chk("oor_we_addrerr", 32'(ae1), 32'd1);
    chk("oor_we_novalid", 32'(dv1), 32'd0);
    tick();
    chk("oor_addrerr_pulse", 32'(ae1), 32'd0);
    a1 = 5'd25; re1 = 1'b1;
    q1.push_back(4'h0);
    tick();
    re1 = 1'b0;
    chk("oor_re_addrerr", 32'(ae1), 32'd1);
    a1 = 5'd31; we1 = 1'b1; re1 = 1'b1;
    q1.push_back(4'h0);
    tick();
    we1 = 1'b0; re1 = 1'b0;
    chk("oor_rw_addrerr", 32'(ae1), 32'd1);

    is1 = 1'b1; im1 = 1'b1;
    tick();
    is1 = 1'b0;
    e = 1; b = 1;
    while (!idn1 && e < 200) begin
      tick();
      e++;
      if (busy1) b++;
    end
    chk("fill1_edges", 32'(e), 32'd21);
    chk("fill1_busy", 32'(b), 32'd20);
    tick();
    rd1(5'd18, 4'h2);
    rd1(5'd19, 4'h3);
    rd1(5'd5, 4'h5);

    repeat (3) tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sync_init.md
Name: ram_sync_init

Overview:
- Parametrised single-port synchronous RAM with a built-in fill sequencer.
- Generalises the 8-bit test RAM to arbitrary width and depth.
- Replaces the ad-hoc test-start preload with a handshaked init engine that fills memory with either a constant or an address-index pattern.
- Adds read-valid signalling and out-of-range address detection. Used as scratch/program memory behind the datapath and as a self-initialising memory for benches.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 5, address width in bits
DEPTH, 32, number of words; must satisfy 1 <= DEPTH <= 2^ADDR_WIDTH

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
address  input  ADDR_WIDTH  read/write word address
we  input  1  write enable
dataIn  input  DATA_WIDTH  write data
re  input  1  read enable
dataOut  output  DATA_WIDTH  registered read data
dataValid  output  1  one-cycle pulse: dataOut updated by a read
initStart  input  1  level request to start a fill, sampled in IDLE
initMode  input  1  0 = fill with initValue; 1 = fill with the word's own address
initValue  input  DATA_WIDTH  constant fill value for mode 0
busy  output  1  fill in progress; we/re ignored
initDone  output  1  one-cycle pulse when a fill completes
addrError  output  1  one-cycle pulse: we or re issued with address >= DEPTH

Behaviour:
- Reset (edge with reset=1):
  - dataOut=0, dataValid=0, busy=0, initDone=0, addrError=0.
  - State=IDLE, fill counter=0.
  - Memory contents are NOT cleared.
  - Reset has priority over all other inputs.
- States: IDLE, FILL.
- IDLE, priority order per edge:
  - initStart=1:
    - Latch initMode and initValue.
    - cnt<=0, go to FILL; busy=1 from the next cycle.
    - we/re in the same cycle are dropped: no write, no dataValid, no addrError.
  - else we=1 and address<DEPTH: mem[address]<=dataIn at this edge.
  - else re=1:
    - dataOut<=mem[address], dataValid=1 for the following cycle (latency 1).
    - Read-first: re and we to the same address on one edge return the OLD word, and the write still occurs.
    - re and we both 1 are serviced together (write and read on the same edge).
  - Address >= DEPTH:
    - Write is ignored.
    - Read loads dataOut=0 and still pulses dataValid.
    - addrError=1 for one cycle (once per edge, even if both we and re are set).
  - dataOut holds its value when no read occurs; dataValid=0.
- FILL:
  - On each edge: mem[cnt]<=fill word, cnt<=cnt+1.
  - Fill word:
    - mode 0: latched initValue.
    - mode 1: cnt zero-extended or truncated to DATA_WIDTH (low bits kept).
  - Edge writing cnt=DEPTH-1: go to IDLE, busy<=0, initDone<=1 for one cycle.
  - busy is high for exactly DEPTH cycles; total start-to-initDone = DEPTH+1 edges.
  - we, re, initStart are ignored while in FILL: no dataValid, no addrError.
  - Changes on initMode/initValue mid-fill have no effect.
- Back-to-back fills: if initStart is still 1 in the cycle initDone is high (IDLE), a new fill starts on that edge.
- Reset mid-fill: return to IDLE with busy=0 and no initDone. Already-written words keep their fill values; the rest keep old contents.
- DEPTH=1: fill lasts one cycle (busy high 1 cycle, then initDone).
- Counter width is ADDR_WIDTH+1 internally so DEPTH=2^ADDR_WIDTH terminates correctly without wrap.

Test Plan:
- Reset, then read address 0 -> dataOut=0 and dataValid=0 right after reset. Write 8'hA5 to address 3, then re at 3 -> dataOut=8'hA5, dataValid=1 exactly one cycle after re.
- Defaults: initStart with mode 0, initValue=8'h05 -> busy=1 for 32 cycles, then initDone pulse. Read addresses 0..19 -> all 8'h05. Mode 1 fill, then read addresses 0..31 -> dataOut==address.
- Write 8'h11 to address 7, then same-edge re+we at address 7 with dataIn=8'h22 -> dataOut=8'h11. Next read of address 7 -> 8'h22.
- DATA_WIDTH=4, DEPTH=20, ADDR_WIDTH=5:
  - we at address 25 -> no write, addrError pulse.
  - re at address 25 -> dataOut=0, dataValid=1, addrError=1.
  - Mode 1 fill -> address 18 reads 4'h2 (truncation).
- During fill, assert we at address 0 with dataIn=8'hFF and re at address 0 -> ignored: no dataValid, and the final content is the fill value.
- Assert reset at fill cycle 10 -> busy=0 next cycle, no initDone. Addresses 0..9 hold the fill value; address 10+ keep prior data. Holding initStart high through initDone -> a second fill starts immediately (busy stays low only during the initDone cycle).
